// File: rtl/cpu_eu_stack_if.sv
// Bus bundle between the execution unit and its hardware LIFO stack.
// The EU side uses the master modport; the stack itself uses the slave modport.
interface cpu_eu_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] D_in;
  logic [WIDTH-1:0] D_out;
  logic             valid;
  logic [PTR_W-1:0] sp;
  logic             empty;
  logic             full;
  logic             err;

  modport master (
    output push, pop, D_in,
    input  D_out, valid, sp, empty, full, err
  );

  modport slave (
    input  push, pop, D_in,
    output D_out, valid, sp, empty, full, err
  );
endinterface

// File: rtl/cpu_eu_stack.sv
// cpu_eu_stack: hardware LIFO beside the EU register pair on the D_in/D_out path.
// Holds return addresses and saved operands; pop data is registered with 1-cycle latency.
// Build option: CPU_EU_STACK_STICKY_ERR_EN makes err sticky until reset;
// without it err pulses for one cycle after each overflow/underflow request.
module cpu_eu_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           reset,
  cpu_eu_stack_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] dOut_q, dOut_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             isEmpty;
  logic             isFull;
  logic [IDX_W-1:0] wrIdx;
  logic [IDX_W-1:0] topIdx;
  logic [IDX_W-1:0] memAddr;
  logic             memWe;
  logic             errEvent;

  assign isEmpty = (sp_q == '0);
  assign isFull  = (sp_q == PTR_W'(DEPTH));
  assign wrIdx   = IDX_W'(sp_q);
  assign topIdx  = IDX_W'(sp_q - PTR_W'(1));

  // Decode push/pop into next pointer, pop data, memory write and error event.
  // Push+pop on a non-empty stack replaces the top; on an empty stack it bypasses D_in.
  always_comb begin
    sp_d     = sp_q;
    dOut_d   = dOut_q;
    valid_d  = 1'b0;
    errEvent = 1'b0;
    memWe    = 1'b0;
    memAddr  = wrIdx;
    case ({bus.push, bus.pop})
      2'b10: begin
        if (isFull) begin
          errEvent = 1'b1;
        end else begin
          memWe   = 1'b1;
          memAddr = wrIdx;
          sp_d    = sp_q + PTR_W'(1);
        end
      end
      2'b01: begin
        if (isEmpty) begin
          errEvent = 1'b1;
        end else begin
          dOut_d  = mem_q[topIdx];
          sp_d    = sp_q - PTR_W'(1);
          valid_d = 1'b1;
        end
      end
      2'b11: begin
        valid_d = 1'b1;
        if (isEmpty) begin
          dOut_d = bus.D_in;
        end else begin
          dOut_d  = mem_q[topIdx];
          memWe   = 1'b1;
          memAddr = topIdx;
        end
      end
      default: begin
      end
    endcase
`ifdef CPU_EU_STACK_STICKY_ERR_EN
    err_d = err_q | errEvent;
`else
    err_d = errEvent;
`endif
  end

  // Control and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q    <= '0;
      dOut_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      dOut_q  <= dOut_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Storage array; its contents after reset are meaningless since sp returns to 0.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem_q[memAddr] <= bus.D_in;
    end
  end

  assign bus.D_out = dOut_q;
  assign bus.valid = valid_q;
  assign bus.sp    = sp_q;
  assign bus.empty = isEmpty;
  assign bus.full  = isFull;
  assign bus.err   = err_q;
endmodule
